// File: rtl/object_stream_gen.sv
// object_stream_gen: raster-scans one OBJ_W x OBJ_H object into FIFO pixel writes of {colour, address}.
// Latency: START at edge k puts the first pixel on the outputs in cycle k+1; DONE follows the last pixel by one cycle.
// Backpressure: OBJ_WRFULL stalls the scan on on-screen pixels only; nothing is dropped or duplicated.
//
// Ports:
//   CLOCK_50, RESET          clock (rising edge) and asynchronous active-low reset
//   START                    one-cycle draw request, taken only while idle
//   OBJ_X, OBJ_Y, OBJ_COLOR  object top-left corner and pixel value, latched with START
//   OBJ_WRFULL               object FIFO full flag, synchronous to CLOCK_50
//   OBJ_WRREQ                FIFO write strobe for the pixel currently presented
//   OBJ_DATA, OBJ_ADDR       pixel value and frame-buffer address (x + y*H_RES)
//   BUSY, DONE               scanning indicator and end-of-object pulse
module object_stream_gen #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int OBJ_W = 16,
  parameter int OBJ_H = 16
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        START,
  input  logic [9:0]  OBJ_X,
  input  logic [9:0]  OBJ_Y,
  input  logic [7:0]  OBJ_COLOR,
  input  logic        OBJ_WRFULL,
  output logic        OBJ_WRREQ,
  output logic [7:0]  OBJ_DATA,
  output logic [18:0] OBJ_ADDR,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [9:0]  COL_LAST  = 10'(OBJ_W - 1);
  localparam logic [9:0]  ROW_LAST  = 10'(OBJ_H - 1);
  localparam logic [10:0] H_LIMIT   = 11'(H_RES);
  localparam logic [10:0] V_LIMIT   = 11'(V_RES);
  localparam logic [19:0] ROW_STEP  = 20'(H_RES);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  color_q, color_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  // Y*H_RES for the current row, kept incrementally so no multiplier sits in the scan path.
  logic [19:0] row_base_q, row_base_d;

  logic [10:0] px_x;
  logic [10:0] px_y;
  logic        in_range;
  logic        scanning;
  logic        consume;
  logic        last_col;
  logic        last_row;

  // Current pixel position; 11 bits so that X+col never wraps back on screen.
  assign px_x     = {1'b0, x_q} + {1'b0, col_q};
  assign px_y     = {1'b0, y_q} + {1'b0, row_q};
  assign in_range = (px_x < H_LIMIT) && (px_y < V_LIMIT);
  assign scanning = (state_q == ST_SCAN);

  // Off-screen pixels always advance; on-screen pixels wait for FIFO room.
  assign consume  = scanning && (!in_range || !OBJ_WRFULL);
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  // Write strobe is combinational on OBJ_WRFULL so a full FIFO is never written.
  assign OBJ_WRREQ = scanning && in_range && !OBJ_WRFULL;
  assign OBJ_DATA  = color_q;
  // Summing at 19 bits gives the same result as a 20-bit sum truncated to 19.
  assign OBJ_ADDR  = row_base_q[18:0] + 19'(x_q) + 19'(col_q);
  assign BUSY      = scanning;
  assign DONE      = (state_q == ST_FIN);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_SCAN;
          x_d        = OBJ_X;
          y_d        = OBJ_Y;
          color_d    = OBJ_COLOR;
          col_d      = '0;
          row_d      = '0;
          row_base_d = 20'(OBJ_Y) * ROW_STEP;
        end
      end

      ST_SCAN: begin
        if (consume) begin
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + 10'd1;
            row_base_d = row_base_q + ROW_STEP;
            if (last_row) begin
              state_d = ST_FIN;
            end
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: tb/tb_object_stream_gen.sv
// tb_object_stream_gen: directed checks of object_stream_gen with a 4x2 object.
// Latency: each scenario starts at an idle cycle and captures a fixed window of cycles.
// Backpressure: OBJ_WRFULL is driven per cycle from a mask to create stalls.
module tb_object_stream_gen;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic        START;
  logic [9:0]  OBJ_X;
  logic [9:0]  OBJ_Y;
  logic [7:0]  OBJ_COLOR;
  logic        OBJ_WRFULL;
  logic        OBJ_WRREQ;
  logic [7:0]  OBJ_DATA;
  logic [18:0] OBJ_ADDR;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  // Per-cycle capture, cycle 1 is the first cycle after the accepting edge.
  logic        wr_at   [1:63];
  logic [18:0] addr_at [1:63];
  logic        busy_at [1:63];
  logic [18:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          wr_n;
  int          done_cyc;
  int          done_n;
  int          busy_n;

  object_stream_gen #(
    .H_RES(640),
    .V_RES(480),
    .OBJ_W(4),
    .OBJ_H(2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .START     (START),
    .OBJ_X     (OBJ_X),
    .OBJ_Y     (OBJ_Y),
    .OBJ_COLOR (OBJ_COLOR),
    .OBJ_WRFULL(OBJ_WRFULL),
    .OBJ_WRREQ (OBJ_WRREQ),
    .OBJ_DATA  (OBJ_DATA),
    .OBJ_ADDR  (OBJ_ADDR),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Address of the i-th write of the 4x2 object at X=10, Y=2.
  function automatic logic [18:0] basic_addr(input int i);
    return 19'((2 + i / 4) * 640 + 10 + (i % 4));
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_start(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c);
    OBJ_X = x;
    OBJ_Y = y;
    OBJ_COLOR = c;
    START = 1'b1;
    @(posedge CLOCK_50);
    #1;
    START = 1'b0;
  endtask

  task automatic capture(input int ncyc, input logic [63:0] full_mask, input logic [63:0] start_mask);
    wr_n = 0;
    done_cyc = 0;
    done_n = 0;
    busy_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      OBJ_WRFULL = full_mask[c-1];
      START = start_mask[c-1];
      @(negedge CLOCK_50);
      wr_at[c] = OBJ_WRREQ;
      addr_at[c] = OBJ_ADDR;
      busy_at[c] = BUSY;
      if (OBJ_WRREQ) begin
        wr_addr[wr_n] = OBJ_ADDR;
        wr_data[wr_n] = OBJ_DATA;
        wr_n++;
      end
      if (BUSY) busy_n++;
      if (DONE) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(posedge CLOCK_50);
      #1;
    end
    OBJ_WRFULL = 1'b0;
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    START = 1'b0;
    OBJ_X = '0;
    OBJ_Y = '0;
    OBJ_COLOR = '0;
    OBJ_WRFULL = 1'b0;
    #5;
    START = 1'b1;
    OBJ_X = 10'd5;
    OBJ_Y = 10'd5;
    OBJ_COLOR = 8'hFF;
    OBJ_WRFULL = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++; if (OBJ_WRREQ !== 1'b0) begin bad++; $display("FAIL rst_wrreq got=%b want=0", OBJ_WRREQ); end
    total++; if (OBJ_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", OBJ_DATA); end
    total++; if (OBJ_ADDR !== 19'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", OBJ_ADDR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", DONE); end
    START = 1'b0;
    OBJ_WRFULL = 1'b0;
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    @(negedge CLOCK_50);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", BUSY); end
    total++; if (OBJ_WRREQ !== 1'b0) begin bad++; $display("FAIL post_rst_wrreq got=%b want=0", OBJ_WRREQ); end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_basic();
    do_start(10'd10, 10'd2, 8'hA5);
    capture(12, 64'h0, 64'h0);
    total++; if (wr_n !== 8) begin bad++; $display("FAIL basic_count got=%0d want=8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      total++; if (wr_addr[i] !== basic_addr(i)) begin bad++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, wr_addr[i], basic_addr(i)); end
      total++; if (wr_data[i] !== 8'hA5) begin bad++; $display("FAIL basic_data[%0d] got=%h want=a5", i, wr_data[i]); end
      total++; if (wr_at[i+1] !== 1'b1) begin bad++; $display("FAIL basic_wrreq_cycle%0d got=%b want=1", i + 1, wr_at[i+1]); end
    end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL basic_done_cycle got=%0d want=9", done_cyc); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_n); end
    total++; if (busy_at[9] !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy_at[9]); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", busy_n); end
  endtask

  task automatic test_stall();
    do_start(10'd10, 10'd2, 8'hA5);
    // Full during cycles 4..6, right after the third write.
    capture(14, 64'h38, 64'h0);
    total++; if (wr_n !== 8) begin bad++; $display("FAIL stall_count got=%0d want=8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      total++; if (wr_addr[i] !== basic_addr(i)) begin bad++; $display("FAIL stall_addr[%0d] got=%0d want=%0d", i, wr_addr[i], basic_addr(i)); end
    end
    for (int c = 4; c <= 6; c++) begin
      total++; if (wr_at[c] !== 1'b0) begin bad++; $display("FAIL stall_wrreq_cycle%0d got=%b want=0", c, wr_at[c]); end
      total++; if (addr_at[c] !== 19'd1293) begin bad++; $display("FAIL stall_addr_hold_cycle%0d got=%0d want=1293", c, addr_at[c]); end
    end
    total++; if (wr_at[7] !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b want=1", wr_at[7]); end
    total++; if (done_cyc !== 12) begin bad++; $display("FAIL stall_done_cycle got=%0d want=12", done_cyc); end
    total++; if (busy_n !== 11) begin bad++; $display("FAIL stall_busy_cycles got=%0d want=11", busy_n); end
  endtask

  task automatic test_clip();
    do_start(10'd638, 10'd479, 8'h3C);
    capture(12, 64'h0, 64'h0);
    total++; if (wr_n !== 2) begin bad++; $display("FAIL clip_count got=%0d want=2", wr_n); end
    total++; if (wr_addr[0] !== 19'd307198) begin bad++; $display("FAIL clip_addr0 got=%0d want=307198", wr_addr[0]); end
    total++; if (wr_addr[1] !== 19'd307199) begin bad++; $display("FAIL clip_addr1 got=%0d want=307199", wr_addr[1]); end
    total++; if (wr_data[0] !== 8'h3C) begin bad++; $display("FAIL clip_data got=%h want=3c", wr_data[0]); end
    total++; if (wr_at[3] !== 1'b0) begin bad++; $display("FAIL clip_wrreq_cycle3 got=%b want=0", wr_at[3]); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL clip_done_cycle got=%0d want=9", done_cyc); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL clip_busy_cycles got=%0d want=8", busy_n); end
  endtask

  task automatic test_offscreen();
    do_start(10'd10, 10'd500, 8'h77);
    capture(12, 64'h0, 64'h0);
    total++; if (wr_n !== 0) begin bad++; $display("FAIL off_count got=%0d want=0", wr_n); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL off_busy_cycles got=%0d want=8", busy_n); end
    total++; if (busy_at[8] !== 1'b1) begin bad++; $display("FAIL off_busy_cycle8 got=%b want=1", busy_at[8]); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL off_done_cycle got=%0d want=9", done_cyc); end
  endtask

  task automatic test_collision();
    do_start(10'd10, 10'd2, 8'hA5);
    // Different object on the inputs while START re-pulses in SCAN (cycles 2, 5) and FIN (cycle 9).
    OBJ_X = 10'd100;
    OBJ_Y = 10'd50;
    OBJ_COLOR = 8'h5A;
    capture(12, 64'h0, 64'h112);
    total++; if (wr_n !== 8) begin bad++; $display("FAIL coll_count got=%0d want=8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      total++; if (wr_addr[i] !== basic_addr(i)) begin bad++; $display("FAIL coll_addr[%0d] got=%0d want=%0d", i, wr_addr[i], basic_addr(i)); end
    end
    total++; if (wr_data[7] !== 8'hA5) begin bad++; $display("FAIL coll_data got=%h want=a5", wr_data[7]); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL coll_done_cycle got=%0d want=9", done_cyc); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL coll_done_pulses got=%0d want=1", done_n); end
    total++; if (busy_at[10] !== 1'b0) begin bad++; $display("FAIL coll_busy_after_fin got=%b want=0", busy_at[10]); end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL coll_busy_cycles got=%0d want=8", busy_n); end
  endtask

  task automatic test_reset_midscan();
    do_start(10'd10, 10'd2, 8'hA5);
    capture(3, 64'h0, 64'h0);
    // Now inside cycle 4, where pixel 1293 would be written.
    #3;
    RESET = 1'b0;
    #1;
    total++; if (OBJ_WRREQ !== 1'b0) begin bad++; $display("FAIL mid_rst_wrreq got=%b want=0", OBJ_WRREQ); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", BUSY); end
    total++; if (OBJ_ADDR !== 19'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d want=0", OBJ_ADDR); end
    total++; if (OBJ_DATA !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", OBJ_DATA); end
    START = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_hold_busy got=%b want=0", BUSY); end
    START = 1'b0;
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rel_busy got=%b want=0", BUSY); end
    do_start(10'd10, 10'd2, 8'hA5);
    capture(12, 64'h0, 64'h0);
    total++; if (wr_n !== 8) begin bad++; $display("FAIL mid_redraw_count got=%0d want=8", wr_n); end
    total++; if (wr_addr[0] !== 19'd1290) begin bad++; $display("FAIL mid_redraw_first got=%0d want=1290", wr_addr[0]); end
    total++; if (wr_addr[7] !== 19'd1933) begin bad++; $display("FAIL mid_redraw_last got=%0d want=1933", wr_addr[7]); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL mid_redraw_done got=%0d want=9", done_cyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clip();
    test_offscreen();
    test_collision();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
